imem_fetch_arbiter: RTL and testbench

//   Owns the 128 x 19-bit instruction memory port. It shares that port between two requesters: the CPU fetch path (PC/INSTRUCTION) and a program loader that writes instructions.

---
 rtl/imem_fetch_arbiter.sv | 151 +++++++++++++++
 tb/tb_imem_fetch_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_arbiter.sv
// imem_fetch_arbiter: shares the 128 x 19-bit instruction memory port between
// the CPU fetch path and a program loader. Reads take READ_LAT cycles, writes
// take one, ties are broken round-robin, and BUSYWAIT stalls the CPU.
// Optional feature macro: FETCH_BUF_EN adds a one-entry fetch buffer that
// answers repeated fetches of the last-read address without a memory access.
module imem_fetch_arbiter #(
  parameter int ADDR_W   = 7,
  parameter int INSTR_W  = 19,
  parameter int READ_LAT = 2
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [31:0]        PC,
  input  logic               FETCH_REQ,
  output logic [INSTR_W-1:0] INSTRUCTION,
  output logic               FETCH_VALID,
  output logic               ADDR_ERR,
  output logic               BUSYWAIT,
  input  logic               LD_REQ,
  input  logic [ADDR_W-1:0]  LD_ADDR,
  input  logic [INSTR_W-1:0] LD_DATA,
  output logic               LD_ACK,
  output logic [ADDR_W-1:0]  MEM_ADDR,
  output logic               MEM_RE,
  output logic               MEM_WE,
  output logic [INSTR_W-1:0] MEM_WDATA,
  input  logic [INSTR_W-1:0] MEM_RDATA
);

  localparam int CNT_W = $clog2(READ_LAT + 1);
  localparam logic GRANT_FETCH  = 1'b0;
  localparam logic GRANT_LOADER = 1'b1;

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               last_grant;
  logic               idle_free;
  logic               grant_fetch;
  logic               grant_ld;
  logic               pc_err;
  logic               read_done;
  logic               buf_hit;
  logic [INSTR_W-1:0] buf_data;

  assign BUSYWAIT = FETCH_REQ & ~FETCH_VALID;

  // Arbitration: idle only accepts once the previous completion pulse is gone,
  // and on a tie the requester that was not served last wins.
  always_comb begin
    idle_free   = (state == IDLE) && !FETCH_VALID && !LD_ACK;
    grant_fetch = idle_free && FETCH_REQ && (!LD_REQ || (last_grant == GRANT_LOADER));
    grant_ld    = idle_free && LD_REQ && !grant_fetch;
    pc_err      = |PC[31:ADDR_W];
    read_done   = (state == READ) && (cnt == CNT_W'(1));
  end

`ifdef FETCH_BUF_EN
  logic              buf_vld;
  logic [ADDR_W-1:0] buf_addr;
  logic [INSTR_W-1:0] buf_word;

  assign buf_hit  = buf_vld && (buf_addr == PC[ADDR_W-1:0]);
  assign buf_data = buf_word;

  // Buffer valid bit: set by every completed memory read, cleared by reset.
  always_ff @(posedge CLK) begin
    if (!RESET)
      buf_vld <= 1'b0;
    else if (read_done)
      buf_vld <= 1'b1;
  end

  // Buffer contents: capture each read; a loader write to the same address keeps it coherent.
  always_ff @(posedge CLK) begin
    if (read_done) begin
      buf_addr <= MEM_ADDR;
      buf_word <= MEM_RDATA;
    end else if (grant_ld && buf_vld && (LD_ADDR == buf_addr)) begin
      buf_word <= LD_DATA;
    end
  end
`else
  assign buf_hit  = 1'b0;
  assign buf_data = '0;
`endif

  // Main sequencer: grants in IDLE, counts read latency in READ, acks in WRITE.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state       <= IDLE;
      cnt         <= '0;
      last_grant  <= GRANT_LOADER;
      INSTRUCTION <= '0;
      FETCH_VALID <= 1'b0;
      ADDR_ERR    <= 1'b0;
      LD_ACK      <= 1'b0;
      MEM_ADDR    <= '0;
      MEM_RE      <= 1'b0;
      MEM_WE      <= 1'b0;
      MEM_WDATA   <= '0;
    end else begin
      FETCH_VALID <= 1'b0;
      ADDR_ERR    <= 1'b0;
      LD_ACK      <= 1'b0;
      MEM_RE      <= 1'b0;
      MEM_WE      <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_fetch) begin
            last_grant <= GRANT_FETCH;
            if (pc_err) begin
              INSTRUCTION <= '0;
              FETCH_VALID <= 1'b1;
              ADDR_ERR    <= 1'b1;
            end else if (buf_hit) begin
              INSTRUCTION <= buf_data;
              FETCH_VALID <= 1'b1;
            end else begin
              MEM_RE   <= 1'b1;
              MEM_ADDR <= PC[ADDR_W-1:0];
              cnt      <= CNT_W'(READ_LAT);
              state    <= READ;
            end
          end else if (grant_ld) begin
            last_grant <= GRANT_LOADER;
            MEM_WE     <= 1'b1;
            MEM_ADDR   <= LD_ADDR;
            MEM_WDATA  <= LD_DATA;
            state      <= WRITE;
          end
        end
        READ: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            INSTRUCTION <= MEM_RDATA;
            FETCH_VALID <= 1'b1;
            state       <= IDLE;
          end
        end
        WRITE: begin
          LD_ACK <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_fetch_arbiter.sv
// Directed testbench for imem_fetch_arbiter with a READ_LAT=2 memory model.
module tb_imem_fetch_arbiter;

  localparam int ADDR_W   = 7;
  localparam int INSTR_W  = 19;
  localparam int READ_LAT = 2;
  localparam logic [18:0] WORD5  = 19'b1000000010001000001;
  localparam logic [18:0] WORD12 = 19'b1001000100000100101;
  localparam logic [18:0] WORD20 = 19'h2A5A5;

  logic               CLK = 1'b0;
  logic               RESET;
  logic [31:0]        PC;
  logic               FETCH_REQ;
  logic [INSTR_W-1:0] INSTRUCTION;
  logic               FETCH_VALID;
  logic               ADDR_ERR;
  logic               BUSYWAIT;
  logic               LD_REQ;
  logic [ADDR_W-1:0]  LD_ADDR;
  logic [INSTR_W-1:0] LD_DATA;
  logic               LD_ACK;
  logic [ADDR_W-1:0]  MEM_ADDR;
  logic               MEM_RE;
  logic               MEM_WE;
  logic [INSTR_W-1:0] MEM_WDATA;
  logic [INSTR_W-1:0] MEM_RDATA = '0;

  logic               seed;
  logic [INSTR_W-1:0] mem [128];

  int checks = 0;
  int errors = 0;

  imem_fetch_arbiter #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .READ_LAT(READ_LAT)) dut (
    .CLK(CLK), .RESET(RESET), .PC(PC), .FETCH_REQ(FETCH_REQ),
    .INSTRUCTION(INSTRUCTION), .FETCH_VALID(FETCH_VALID), .ADDR_ERR(ADDR_ERR),
    .BUSYWAIT(BUSYWAIT), .LD_REQ(LD_REQ), .LD_ADDR(LD_ADDR), .LD_DATA(LD_DATA),
    .LD_ACK(LD_ACK), .MEM_ADDR(MEM_ADDR), .MEM_RE(MEM_RE), .MEM_WE(MEM_WE),
    .MEM_WDATA(MEM_WDATA), .MEM_RDATA(MEM_RDATA)
  );

  always #5 CLK = ~CLK;

  // Memory model: data for a read is registered one edge after MEM_RE is seen,
  // so it is stable at the second edge after the strobe rises.
  always @(posedge CLK) begin
    if (MEM_WE)
      mem[MEM_ADDR] <= MEM_WDATA;
    else if (seed)
      mem[5] <= WORD5;
    if (MEM_RE)
      MEM_RDATA <= mem[MEM_ADDR];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_fetch(input logic [31:0] pc, output logic [18:0] instr,
                          output logic err, output int lat, output int re_cnt);
    FETCH_REQ = 1'b1;
    PC        = pc;
    lat       = 0;
    re_cnt    = 0;
    while (lat < 20) begin
      tick();
      lat++;
      if (MEM_RE) re_cnt++;
      if (FETCH_VALID) break;
    end
    instr = INSTRUCTION;
    err   = ADDR_ERR;
    chk("fetch_done", {31'd0, FETCH_VALID}, 32'd1);
    FETCH_REQ = 1'b0;
  endtask

  initial begin
    logic [18:0] instr;
    logic        err;
    int          lat;
    int          re_cnt;
    int          both;
    int          ngrant;
    logic [7:0]  pat;
    logic        seen;

    // Reset with random inputs
    RESET     = 1'b0;
    seed      = 1'b1;
    FETCH_REQ = 1'($urandom_range(1));
    PC        = $urandom;
    LD_REQ    = 1'($urandom_range(1));
    LD_ADDR   = 7'($urandom);
    LD_DATA   = 19'($urandom);
    tick();
    tick();
    chk("rst_instr", 32'(INSTRUCTION), 32'd0);
    chk("rst_fv", 32'(FETCH_VALID), 32'd0);
    chk("rst_aerr", 32'(ADDR_ERR), 32'd0);
    chk("rst_ack", 32'(LD_ACK), 32'd0);
    chk("rst_maddr", 32'(MEM_ADDR), 32'd0);
    chk("rst_re", 32'(MEM_RE), 32'd0);
    chk("rst_we", 32'(MEM_WE), 32'd0);
    chk("rst_wdata", 32'(MEM_WDATA), 32'd0);
    chk("rst_busy", 32'(BUSYWAIT), 32'(FETCH_REQ));
    FETCH_REQ = 1'b0;
    LD_REQ    = 1'b0;
    PC        = 32'd0;
    seed      = 1'b0;
    RESET     = 1'b1;
    seen      = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      seen = seen | FETCH_VALID | MEM_RE | MEM_WE | LD_ACK | ADDR_ERR;
    end
    chk("idle_quiet", 32'(seen), 32'd0);

    // Fetch of address 5
    FETCH_REQ = 1'b1;
    PC        = 32'd5;
    #1;
    chk("f5_busy0", 32'(BUSYWAIT), 32'd1);
    tick();
    chk("f5_re_e0", 32'(MEM_RE), 32'd1);
    chk("f5_addr", 32'(MEM_ADDR), 32'd5);
    chk("f5_fv_e0", 32'(FETCH_VALID), 32'd0);
    tick();
    chk("f5_re_e1", 32'(MEM_RE), 32'd0);
    chk("f5_fv_e1", 32'(FETCH_VALID), 32'd0);
    chk("f5_busy1", 32'(BUSYWAIT), 32'd1);
    tick();
    chk("f5_fv_e2", 32'(FETCH_VALID), 32'd1);
    chk("f5_instr", 32'(INSTRUCTION), 32'(WORD5));
    chk("f5_aerr", 32'(ADDR_ERR), 32'd0);
    chk("f5_busy2", 32'(BUSYWAIT), 32'd0);
    FETCH_REQ = 1'b0;
    tick();
    chk("f5_fv_drop", 32'(FETCH_VALID), 32'd0);
    chk("f5_hold", 32'(INSTRUCTION), 32'(WORD5));

    // Loader write to address 12, then read it back
    LD_REQ  = 1'b1;
    LD_ADDR = 7'd12;
    LD_DATA = WORD12;
    tick();
    chk("ld_we", 32'(MEM_WE), 32'd1);
    chk("ld_addr", 32'(MEM_ADDR), 32'd12);
    chk("ld_wdata", 32'(MEM_WDATA), 32'(WORD12));
    chk("ld_ack_e0", 32'(LD_ACK), 32'd0);
    chk("ld_re_e0", 32'(MEM_RE), 32'd0);
    tick();
    chk("ld_we_e1", 32'(MEM_WE), 32'd0);
    chk("ld_ack_e1", 32'(LD_ACK), 32'd1);
    LD_REQ = 1'b0;
    tick();
    chk("ld_ack_drop", 32'(LD_ACK), 32'd0);
    do_fetch(32'd12, instr, err, lat, re_cnt);
    chk("f12_instr", 32'(instr), 32'(WORD12));
    chk("f12_lat", 32'(lat), 32'd3);
    chk("f12_re", 32'(re_cnt), 32'd1);
    tick();

    // Out-of-range fetch
    FETCH_REQ = 1'b1;
    PC        = 32'd200;
    tick();
    chk("oor_fv", 32'(FETCH_VALID), 32'd1);
    chk("oor_aerr", 32'(ADDR_ERR), 32'd1);
    chk("oor_instr", 32'(INSTRUCTION), 32'd0);
    chk("oor_re", 32'(MEM_RE), 32'd0);
    FETCH_REQ = 1'b0;
    tick();
    chk("oor_fv_drop", 32'(FETCH_VALID), 32'd0);
    chk("oor_aerr_drop", 32'(ADDR_ERR), 32'd0);

    // Both requesters held from reset release: grants must alternate
    RESET = 1'b0;
    tick();
    tick();
    FETCH_REQ = 1'b1;
    PC        = 32'd5;
    LD_REQ    = 1'b1;
    LD_ADDR   = 7'd20;
    LD_DATA   = WORD20;
    RESET     = 1'b1;
    both      = 0;
    ngrant    = 0;
    pat       = '0;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (MEM_RE && MEM_WE) both++;
      if (MEM_RE) begin pat = {pat[6:0], 1'b1}; ngrant++; end
      if (MEM_WE) begin pat = {pat[6:0], 1'b0}; ngrant++; end
    end
    FETCH_REQ = 1'b0;
    LD_REQ    = 1'b0;
    chk("rr_overlap", 32'(both), 32'd0);
    chk("rr_count", 32'(ngrant), 32'd4);
    chk("rr_order", 32'(pat), 32'h0A);
    tick();
    tick();

    // Reset one edge after a fetch is accepted
    FETCH_REQ = 1'b1;
    PC        = 32'd5;
    tick();
    chk("abort_re_e0", 32'(MEM_RE), 32'd1);
    RESET     = 1'b0;
    FETCH_REQ = 1'b0;
    tick();
    chk("abort_re", 32'(MEM_RE), 32'd0);
    chk("abort_fv", 32'(FETCH_VALID), 32'd0);
    RESET = 1'b1;
    seen  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      seen = seen | FETCH_VALID | MEM_RE;
    end
    chk("abort_quiet", 32'(seen), 32'd0);

`ifdef FETCH_BUF_EN
    do_fetch(32'd5, instr, err, lat, re_cnt);
    chk("buf_miss_instr", 32'(instr), 32'(WORD5));
    chk("buf_miss_lat", 32'(lat), 32'd3);
    tick();
    do_fetch(32'd5, instr, err, lat, re_cnt);
    chk("buf_hit_instr", 32'(instr), 32'(WORD5));
    chk("buf_hit_lat", 32'(lat), 32'd1);
    chk("buf_hit_re", 32'(re_cnt), 32'd0);
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
